// File: rtl/vedic_mac_accum_pkg.sv
// rtl/vedic_mac_accum_pkg.sv - shared constants, FSM states and vedic 2x2 helper for the MAC front end
package vedic_mac_accum_pkg;

    // Product width delivered by the 4x4 vedic multiplier; fixed by the multiplier.
    localparam int PROD_W = 8;

    // Operand width of each multiplicand/multiplier.
    localparam int OPND_W = 4;

    // Encodings are fixed so that debug dumps match the rest of the float_MAC datapath.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } mac_state_e;

    // Urdhva-tiryagbhyam 2x2 partial multiplier: vertical, crosswise, vertical.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
        logic p0;
        logic cross_s;
        logic cross_c;
        logic hi;
        p0      = x[0] & y[0];
        cross_s = (x[1] & y[0]) ^ (x[0] & y[1]);
        cross_c = (x[1] & y[0]) & (x[0] & y[1]);
        hi      = x[1] & y[1];
        return {hi & cross_c, hi ^ cross_c, cross_s, p0};
    endfunction

endpackage

// File: rtl/vedic_4bit.sv
// rtl/vedic_4bit.sv - combinational 4x4 unsigned vedic multiplier built from four 2x2 blocks
module vedic_4bit
    import vedic_mac_accum_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] out
);

    // Partial products of the operand halves: q0=lo*lo, q1=hi*lo, q2=lo*hi, q3=hi*hi.
    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;

    // Crosswise sum and the upper six result bits.
    logic [4:0] mid;
    logic [5:0] upper;

    assign q0 = vedic_2x2(a[1:0], b[1:0]);
    assign q1 = vedic_2x2(a[3:2], b[1:0]);
    assign q2 = vedic_2x2(a[1:0], b[3:2]);
    assign q3 = vedic_2x2(a[3:2], b[3:2]);

    // The two crosswise terms share weight 4, so add them first.
    assign mid   = {1'b0, q1} + {1'b0, q2};

    // Bits [7:2] collect the carry-in from q0, the crosswise sum and q3 at weight 16.
    // The true result never exceeds 225, so six bits cannot overflow here.
    assign upper = {4'b0000, q0[3:2]} + {1'b0, mid} + {q3, 2'b00};

    assign out   = {upper, q0[1:0]};

endmodule

// File: rtl/vedic_mac_accum.sv
// rtl/vedic_mac_accum.sv - burst multiply-accumulate with saturating sum and valid/ready result
module vedic_mac_accum
    import vedic_mac_accum_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        a,
    input  logic [3:0]        b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf,
    output logic              busy
);

    mac_state_e         state;
    mac_state_e         next_state;

    logic [LEN_W-1:0]   count;
    logic [PROD_W-1:0]  prod;
    logic               p_vld;
    logic [ACC_W-1:0]   acc;
    logic               ovf_q;

    logic [PROD_W-1:0]  mul_out;
    logic               handshake;
    logic               burst_start;
    logic               last_term;
    logic [ACC_W:0]     acc_ext;

    vedic_4bit u_mul (
        .a   (a),
        .b   (b),
        .out (mul_out)
    );

    // Status outputs are pure functions of the state so they drop immediately on reset.
    assign in_ready    = (state == S_RUN);
    assign out_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign sum         = acc;
    assign ovf         = ovf_q;

    assign handshake   = in_valid & in_ready;
    assign burst_start = (state == S_IDLE) & start;
    assign last_term   = (count == LEN_W'(1));

    // One bit wider than the accumulator so the carry-out flags saturation.
    assign acc_ext     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DRAIN exists only to let the final registered product reach acc.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (handshake && last_term) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                next_state = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Remaining-term counter: loaded on start, decremented only by accepted pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (burst_start) begin
            count <= len;
        end else if (handshake) begin
            count <= count - LEN_W'(1);
        end
    end

    // Product pipeline register; p_vld marks a product waiting to be accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            p_vld <= 1'b0;
        end else begin
            p_vld <= handshake;
            if (handshake) begin
                prod <= mul_out;
            end
        end
    end

    // Saturating accumulator with a sticky overflow flag cleared only by a new burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (burst_start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (p_vld) begin
            if (acc_ext[ACC_W]) begin
                acc   <= '1;
                ovf_q <= 1'b1;
            end else begin
                acc   <= acc_ext[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_vedic_mac_accum.sv
// tb/tb_vedic_mac_accum.sv - randomized self-checking bench for vedic_mac_accum at two accumulator widths
module tb_vedic_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = 4'd0;
    logic        in_valid = 1'b0;
    logic [3:0]  a = 4'd0;
    logic [3:0]  b = 4'd0;
    logic        out_ready = 1'b0;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [15:0] sum_w;
    logic        ovf_w;
    logic        busy_w;

    logic        in_ready_n;
    logic        out_valid_n;
    logic [7:0]  sum_n;
    logic        ovf_n;
    logic        busy_n;

    int vectors = 0;
    int miscompares = 0;

    int qa[$];
    int qb[$];
    int qgap[$];

    vedic_mac_accum #(.ACC_W(16), .LEN_W(4)) dut_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .sum       (sum_w),
        .ovf       (ovf_w),
        .busy      (busy_w)
    );

    vedic_mac_accum #(.ACC_W(8), .LEN_W(4)) dut_narrow (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready_n),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_n),
        .out_ready (out_ready),
        .sum       (sum_n),
        .ovf       (ovf_n),
        .busy      (busy_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input bit ir, input bit ov, input bit bz);
        check({tag, ".in_ready_w"},  {31'd0, in_ready_w},  {31'd0, ir});
        check({tag, ".out_valid_w"}, {31'd0, out_valid_w}, {31'd0, ov});
        check({tag, ".busy_w"},      {31'd0, busy_w},      {31'd0, bz});
        check({tag, ".in_ready_n"},  {31'd0, in_ready_n},  {31'd0, ir});
        check({tag, ".out_valid_n"}, {31'd0, out_valid_n}, {31'd0, ov});
        check({tag, ".busy_n"},      {31'd0, busy_n},      {31'd0, bz});
    endtask

    task automatic check_result(input string tag, input int total);
        int exp_w;
        int exp_n;
        exp_w = (total >= 65536) ? 65535 : total;
        exp_n = (total >= 256) ? 255 : total;
        check({tag, ".sum_w"}, {16'd0, sum_w}, exp_w);
        check({tag, ".ovf_w"}, {31'd0, ovf_w}, (total >= 65536) ? 1 : 0);
        check({tag, ".sum_n"}, {24'd0, sum_n}, exp_n);
        check({tag, ".ovf_n"}, {31'd0, ovf_n}, (total >= 256) ? 1 : 0);
    endtask

    // Runs one burst from the operand queues, then holds DONE for bp cycles before consuming.
    task automatic run_burst(input string tag, input int bp, input bit junk);
        int n;
        int total;
        n = qa.size();
        total = 0;
        for (int i = 0; i < n; i++) total += qa[i] * qb[i];

        start = 1'b1;
        len = n[3:0];
        tick();
        start = 1'b0;
        if (n == 0) begin
            check_ctrl({tag, ".zero"}, 1'b0, 1'b1, 1'b1);
        end else begin
            check_ctrl({tag, ".run"}, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < n; i++) begin
                if (qgap[i] > 0) begin
                    in_valid = 1'b0;
                    for (int g = 0; g < qgap[i]; g++) begin
                        tick();
                        check({tag, ".gap_ready"}, {31'd0, in_ready_w}, 1);
                    end
                end
                a = qa[i][3:0];
                b = qb[i][3:0];
                in_valid = 1'b1;
                check({tag, ".hs_ready"}, {31'd0, in_ready_w}, 1);
                tick();
            end
            in_valid = junk;
            a = 4'($urandom);
            b = 4'($urandom);
            check_ctrl({tag, ".drain"}, 1'b0, 1'b0, 1'b1);
            tick();
            check_ctrl({tag, ".done"}, 1'b0, 1'b1, 1'b1);
        end
        check_result(tag, total);

        for (int c = 0; c < bp; c++) begin
            start = 1'b1;
            len = 4'($urandom_range(1, 15));
            tick();
            start = 1'b0;
            check_ctrl({tag, ".hold"}, 1'b0, 1'b1, 1'b1);
            check_result({tag, ".hold"}, total);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check_ctrl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
        check_result({tag, ".idle"}, total);
    endtask

    initial begin
        // Reset state while rst_n is held low.
        #12;
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check_result("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check_ctrl("post_reset", 1'b0, 1'b0, 1'b0);

        // Back-to-back burst.
        qa = '{15, 3, 0};
        qb = '{15, 4, 9};
        qgap = '{0, 0, 0};
        run_burst("b2b", 0, 1'b0);

        // Gapped burst: three idle cycles before the second pair.
        qa = '{2, 5};
        qb = '{3, 5};
        qgap = '{0, 3};
        run_burst("gapped", 0, 1'b0);

        // Zero length burst.
        qa.delete();
        qb.delete();
        qgap.delete();
        run_burst("zero_len", 0, 1'b0);

        // Saturation on the narrow accumulator, then a fresh burst clears ovf.
        qa = '{15, 15};
        qb = '{15, 15};
        qgap = '{0, 0};
        run_burst("saturate", 0, 1'b0);
        qa = '{1};
        qb = '{1};
        qgap = '{0};
        run_burst("after_sat", 0, 1'b0);

        // Backpressure in DONE with stray start pulses and junk in_valid.
        qa = '{7, 9, 11};
        qb = '{6, 8, 13};
        qgap = '{1, 0, 2};
        run_burst("backpress", 5, 1'b1);

        // Randomized bursts.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(0, 15);
            qa.delete();
            qb.delete();
            qgap.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back($urandom_range(0, 15));
                qb.push_back($urandom_range(0, 15));
                qgap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_burst("rnd", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a burst.
        start = 1'b1;
        len = 4'd5;
        tick();
        start = 1'b0;
        a = 4'd3;
        b = 4'd3;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_ctrl("mid_reset", 1'b0, 1'b0, 1'b0);
        check_result("mid_reset", 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_ctrl("after_reset", 1'b0, 1'b0, 1'b0);

        // Block is usable again after the interrupted burst.
        qa = '{4, 2};
        qb = '{4, 8};
        qgap = '{0, 0};
        run_burst("recover", 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
